// File: rtl/game_pkg.sv
// Shared constants for the whack-a-mole game front end.
// Button count, id width, debounce defaults and raw pin polarity.
package game_pkg;

  localparam int NUM_BTN = 4;
  localparam int BTN_ID_W = $clog2(NUM_BTN);
  localparam int DEBOUNCE_CYCLES = 250000;
  localparam int DEBOUNCE_CNT_W = 18;
  localparam logic BTN_PRESSED = 1'b0;

endpackage

// File: rtl/button_conditioner_if.sv
// Press-event valid/ready channel from the button front end
// to the game controller.
interface button_conditioner_if #(
  parameter int ID_W = game_pkg::BTN_ID_W
);

  logic            press_valid;
  logic [ID_W-1:0] press_id;
  logic            press_ready;

  modport master (
    output press_valid,
    output press_id,
    input  press_ready
  );

  modport slave (
    input  press_valid,
    input  press_id,
    output press_ready
  );

endinterface

// File: rtl/button_debounce.sv
// One button channel: 2-FF synchroniser, stability counter
// and registered press-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W = game_pkg::DEBOUNCE_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic pulse
);

  import game_pkg::*;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
        // only the released->pressed flip produces an event
        pulse  <= (stable != BTN_PRESSED);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = ~stable;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: per-channel debounce, pending presses,
// round-robin arbiter and press-event output register.
module button_conditioner #(
  parameter int NUM_BTN = game_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W = game_pkg::DEBOUNCE_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  button_conditioner_if.master ev,
  output logic               overflow
);

  import game_pkg::*;

  localparam int ID_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] req;
  logic [NUM_BTN-1:0] take;
  logic [NUM_BTN-1:0] pend_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    nxt_id;
  logic [ID_W-1:0]    id_q;
  logic               valid_q;
  logic               found;
  logic               load;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_db (
      .clk(clk),
      .reset(reset),
      .btn_n(btn_n[g]),
      .level(btn_level[g]),
      .pulse(press_pulse[g])
    );
  end

  // a pulse can be forwarded in the same cycle it arrives
  assign req  = pend | press_pulse;
  assign load = ~valid_q | ev.press_ready;

  always_comb begin
    found  = 1'b0;
    nxt_id = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_BTN]) begin
        found  = 1'b1;
        nxt_id = ID_W'((int'(rr_ptr) + k) % NUM_BTN);
      end
    end
  end

  always_comb begin
    take     = '0;
    pend_nxt = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      take[i] = load & found & (nxt_id == ID_W'(i));
      pend_nxt[i] = take[i] ? (pend[i] & press_pulse[i])
                            : (pend[i] | press_pulse[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      id_q     <= '0;
      rr_ptr   <= ID_W'(NUM_BTN - 1);
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= found;
        if (found) begin
          id_q   <= nxt_id;
          rr_ptr <= nxt_id;
        end
      end
      pend <= pend_nxt;
      if (|(press_pulse & pend & ~take)) overflow <= 1'b1;
    end
  end

  assign ev.press_valid = valid_q;
  assign ev.press_id    = id_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle
// debounce threshold.
module tb_button_conditioner;

  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic       overflow;
  logic       ready;

  int n_assert = 0;
  int n_fail = 0;

  button_conditioner_if #(.ID_W(2)) ev ();

  assign ev.press_ready = ready;

  button_conditioner #(
    .NUM_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .ev(ev),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn_n = 4'hF;
    ready = 1'b0;
    ticks(2);
    reset = 1'b0;
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_pulse", 32'(press_pulse), 32'h0);
    chk("rst_valid", 32'(ev.press_valid), 32'h0);
    chk("rst_id", 32'(ev.press_id), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // clean press on button 2
    btn_n = 4'b1011;
    ticks(5);
    chk("clean_pulse_e4", 32'(press_pulse), 32'h0);
    chk("clean_level_e4", 32'(btn_level), 32'h0);
    tick();
    chk("clean_pulse_e5", 32'(press_pulse), 32'h4);
    chk("clean_level_e5", 32'(btn_level), 32'h4);
    chk("clean_valid_e5", 32'(ev.press_valid), 32'h0);
    tick();
    chk("clean_pulse_e6", 32'(press_pulse), 32'h0);
    chk("clean_valid_e6", 32'(ev.press_valid), 32'h1);
    chk("clean_id_e6", 32'(ev.press_id), 32'h2);
    ready = 1'b1;
    tick();
    chk("clean_valid_acc", 32'(ev.press_valid), 32'h0);
    ready = 1'b0;

    // release: no event, level falls after edge 5
    btn_n = 4'hF;
    ticks(5);
    chk("rel_level_e4", 32'(btn_level), 32'h4);
    tick();
    chk("rel_level_e5", 32'(btn_level), 32'h0);
    chk("rel_pulse", 32'(press_pulse), 32'h0);
    tick();
    chk("rel_valid", 32'(ev.press_valid), 32'h0);

    // bounce on button 0
    btn_n = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bounce_pulse_lo", 32'(press_pulse), 32'h0);
    end
    btn_n = 4'b1111;
    tick();
    chk("bounce_pulse_hi", 32'(press_pulse), 32'h0);
    btn_n = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bounce_pulse_settle", 32'(press_pulse), 32'h0);
      chk("bounce_level_settle", 32'(btn_level), 32'h0);
    end
    tick();
    chk("bounce_pulse_e9", 32'(press_pulse), 32'h1);
    tick();
    chk("bounce_pulse_e10", 32'(press_pulse), 32'h0);
    chk("bounce_valid", 32'(ev.press_valid), 32'h1);
    chk("bounce_id", 32'(ev.press_id), 32'h0);
    ready = 1'b1;
    tick();
    chk("bounce_acc", 32'(ev.press_valid), 32'h0);
    ready = 1'b0;
    btn_n = 4'hF;
    ticks(8);
    chk("bounce_rel_level", 32'(btn_level), 32'h0);

    // simultaneous presses on 0, 1 and 3 after a fresh reset
    do_reset();
    btn_n = 4'b0100;
    ticks(6);
    chk("sim_pulse", 32'(press_pulse), 32'hB);
    tick();
    chk("sim_valid", 32'(ev.press_valid), 32'h1);
    chk("sim_id0", 32'(ev.press_id), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sim_stall_valid", 32'(ev.press_valid), 32'h1);
      chk("sim_stall_id", 32'(ev.press_id), 32'h0);
    end
    ready = 1'b1;
    tick();
    chk("sim_valid1", 32'(ev.press_valid), 32'h1);
    chk("sim_id1", 32'(ev.press_id), 32'h1);
    tick();
    chk("sim_valid3", 32'(ev.press_valid), 32'h1);
    chk("sim_id3", 32'(ev.press_id), 32'h3);
    tick();
    chk("sim_drained", 32'(ev.press_valid), 32'h0);
    chk("sim_ovf", 32'(overflow), 32'h0);
    ready = 1'b0;
    btn_n = 4'hF;
    ticks(8);

    // overflow: second press on 1 while its first is pending
    do_reset();
    btn_n = 4'b1100;
    ticks(7);
    chk("ovf_valid", 32'(ev.press_valid), 32'h1);
    chk("ovf_id0", 32'(ev.press_id), 32'h0);
    chk("ovf_pre", 32'(overflow), 32'h0);
    btn_n = 4'b1110;
    ticks(7);
    chk("ovf_rel_level", 32'(btn_level), 32'h1);
    chk("ovf_mid", 32'(overflow), 32'h0);
    btn_n = 4'b1100;
    ticks(7);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_still_id0", 32'(ev.press_id), 32'h0);
    ready = 1'b1;
    tick();
    chk("ovf_valid1", 32'(ev.press_valid), 32'h1);
    chk("ovf_id1", 32'(ev.press_id), 32'h1);
    tick();
    chk("ovf_single", 32'(ev.press_valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    ready = 1'b0;
    btn_n = 4'hF;
    ticks(8);

    // reset mid-handshake and mid-debounce
    do_reset();
    btn_n = 4'b1011;
    ticks(7);
    chk("mid_valid", 32'(ev.press_valid), 32'h1);
    chk("mid_id", 32'(ev.press_id), 32'h2);
    btn_n = 4'b0011;
    ticks(3);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(ev.press_valid), 32'h0);
    chk("mid_rst_id", 32'(ev.press_id), 32'h0);
    chk("mid_rst_level", 32'(btn_level), 32'h0);
    chk("mid_rst_pulse", 32'(press_pulse), 32'h0);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    ticks(5);
    chk("requal_e4", 32'(btn_level), 32'h0);
    tick();
    chk("requal_level", 32'(btn_level), 32'hC);
    chk("requal_pulse", 32'(press_pulse), 32'hC);
    tick();
    chk("requal_valid", 32'(ev.press_valid), 32'h1);
    chk("requal_id", 32'(ev.press_id), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
